// File: rtl/bcd_display_pkg.sv
// rtl/bcd_display_pkg.sv - segment patterns, slot encoding and digit-enable codes
package bcd_display_pkg;

  typedef enum logic {
    SLOT_UNITS = 1'b0,
    SLOT_TENS  = 1'b1
  } slot_e;

  // Active-high patterns, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_E     = 7'h79;
  localparam logic [6:0] SEG_DASH  = 7'h40;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  localparam logic [1:0] AN_OFF   = 2'b00;
  localparam logic [1:0] AN_UNITS = 2'b01;
  localparam logic [1:0] AN_TENS  = 2'b10;

  function automatic logic [1:0] slot_to_an(slot_e s);
    return (s == SLOT_TENS) ? AN_TENS : AN_UNITS;
  endfunction

endpackage

// File: rtl/bcd_to_7seg.sv
// rtl/bcd_to_7seg.sv - combinational BCD digit to active-high 7-segment pattern
module bcd_to_7seg
  import bcd_display_pkg::*;
(
  input  logic [3:0] digit,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_DASH;
    case (digit)
      4'd0: seg = SEG_0;
      4'd1: seg = SEG_1;
      4'd2: seg = SEG_2;
      4'd3: seg = SEG_3;
      4'd4: seg = SEG_4;
      4'd5: seg = SEG_5;
      4'd6: seg = SEG_6;
      4'd7: seg = SEG_7;
      4'd8: seg = SEG_8;
      4'd9: seg = SEG_9;
      default: seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/bcd_display_mux.sv
// rtl/bcd_display_mux.sv - 2-digit multiplexed 7-segment driver for BCD adder results
module bcd_display_mux
  import bcd_display_pkg::*;
#(
  parameter int PRESCALE       = 4,
  parameter int BLINK_DIV      = 8,
  parameter bit SEG_ACTIVE_LOW = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [3:0] tens,
  input  logic [3:0] units,
  input  logic       flag,
  output logic [6:0] seg,
  output logic [1:0] an
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int BW = $clog2(BLINK_DIV + 1);
  localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);
  localparam logic [6:0]    SEG_RESET  = SEG_ACTIVE_LOW ? ~SEG_BLANK : SEG_BLANK;

  logic [PW-1:0] presc;
  slot_e         slot, slot_nxt;
  logic [3:0]    disp_tens, disp_units, pend_tens, pend_units;
  logic          disp_flag, pend_flag, pend_full;
  logic          blink_on;
  logic [BW-1:0] blink_cnt;

  logic          tc, boundary, swap, accept;
  logic [3:0]    digit_sel;
  logic [6:0]    digit_seg, seg_val, seg_nxt;

  bcd_to_7seg u_dec (
    .digit (digit_sel),
    .seg   (digit_seg)
  );

  always_comb begin
    tc        = (presc == PRESC_LAST);
    boundary  = tc && (slot == SLOT_TENS);
    swap      = boundary && pend_full;
    accept    = in_valid && in_ready;
    slot_nxt  = slot;
    if (tc) slot_nxt = (slot == SLOT_UNITS) ? SLOT_TENS : SLOT_UNITS;

    digit_sel = (slot == SLOT_TENS) ? disp_tens : disp_units;
    seg_val   = digit_seg;
    if (disp_flag)
      seg_val = blink_on ? SEG_E : SEG_BLANK;
    else if ((slot == SLOT_TENS) && (disp_tens == 4'd0))
      seg_val = SEG_BLANK;
    seg_nxt   = SEG_ACTIVE_LOW ? ~seg_val : seg_val;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      presc      <= '0;
      slot       <= SLOT_UNITS;
      disp_tens  <= 4'd0;
      disp_units <= 4'd0;
      disp_flag  <= 1'b0;
      pend_tens  <= 4'd0;
      pend_units <= 4'd0;
      pend_flag  <= 1'b0;
      pend_full  <= 1'b0;
      in_ready   <= 1'b1;
      blink_on   <= 1'b1;
      blink_cnt  <= '0;
      seg        <= SEG_RESET;
      an         <= AN_OFF;
    end else begin
      presc <= tc ? '0 : presc + 1'b1;
      slot  <= slot_nxt;
      seg   <= seg_nxt;
      an    <= slot_to_an(slot);

      // accept and swap never coincide: in_ready is low whenever pending is full
      if (swap) begin
        disp_tens  <= pend_tens;
        disp_units <= pend_units;
        disp_flag  <= pend_flag;
        pend_full  <= 1'b0;
        in_ready   <= 1'b1;
        blink_cnt  <= '0;
        blink_on   <= 1'b1;
      end else begin
        if (accept) begin
          pend_tens  <= tens;
          pend_units <= units;
          pend_flag  <= flag;
          pend_full  <= 1'b1;
          in_ready   <= 1'b0;
        end
        if (boundary) begin
          if (blink_cnt == BLINK_LAST) begin
            blink_cnt <= '0;
            blink_on  <= ~blink_on;
          end else begin
            blink_cnt <= blink_cnt + 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_bcd_display_mux.sv
// tb/tb_bcd_display_mux.sv - directed scoreboard bench for bcd_display_mux
module tb_bcd_display_mux;

  localparam int PRESCALE  = 4;
  localparam int BLINK_DIV = 2;
  localparam int FRAME     = 2 * PRESCALE;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic [3:0] tens = 4'd0;
  logic [3:0] units = 4'd0;
  logic       flag = 1'b0;
  logic       in_ready;
  logic [6:0] seg;
  logic [1:0] an;

  bcd_display_mux #(
    .PRESCALE       (PRESCALE),
    .BLINK_DIV      (BLINK_DIV),
    .SEG_ACTIVE_LOW (1'b0)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .tens     (tens),
    .units    (units),
    .flag     (flag),
    .seg      (seg),
    .an       (an)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         start;
    logic [3:0] t;
    logic [3:0] u;
    logic       f;
  } disp_t;

  disp_t q[$];
  disp_t cur = '{start: 0, t: 4'd0, u: 4'd0, f: 1'b0};
  int    e = 0;
  int    tests = 0;
  int    fails = 0;
  bit    last_xfer = 1'b0;

  logic [6:0] dec_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40};

  // Expected pattern at output edge k: frame-relative slot, blink phase counted from the swap
  function automatic logic [6:0] exp_seg(int k);
    int f;
    if (cur.f) begin
      f = (k - cur.start) / FRAME;
      return (((f / BLINK_DIV) % 2) == 0) ? 7'h79 : 7'h00;
    end
    if ((k % FRAME) >= PRESCALE) return (cur.t == 4'd0) ? 7'h00 : dec_tab[cur.t];
    return dec_tab[cur.u];
  endfunction

  task automatic check(string tag, logic [7:0] obs, logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s edge=%0d observed=%h expected=%h", tag, e - 1, obs, exp);
    end
  endtask

  task automatic step();
    bit    xfer;
    int    j;
    int    b;
    int    k;
    bit    exp_ready;
    disp_t d;
    xfer = in_valid && in_ready && rst_n;
    @(posedge clk);
    last_xfer = xfer;
    if (!rst_n) begin
      e = 0;
      q.delete();
      cur = '{start: 0, t: 4'd0, u: 4'd0, f: 1'b0};
    end else begin
      j = e;
      e++;
      if (xfer) begin
        b = (j / FRAME) * FRAME + FRAME - 1;
        if (b == j) b += FRAME;
        d.start = b + 1;
        d.t = tens;
        d.u = units;
        d.f = flag;
        q.push_back(d);
      end
    end
    @(negedge clk);
    if (!rst_n) begin
      check("rst_seg", {1'b0, seg}, 8'h00);
      check("rst_an", {6'b0, an}, 8'h00);
      check("rst_ready", {7'b0, in_ready}, 8'h01);
    end else begin
      k = e - 1;
      while (q.size() > 0 && k >= q[0].start) cur = q.pop_front();
      exp_ready = 1'b1;
      foreach (q[i]) if (k < q[i].start - 1) exp_ready = 1'b0;
      check("an", {6'b0, an}, ((k % FRAME) < PRESCALE) ? 8'h01 : 8'h02);
      check("seg", {1'b0, seg}, {1'b0, exp_seg(k)});
      check("in_ready", {7'b0, in_ready}, {7'b0, exp_ready});
    end
  endtask

  task automatic run(int n);
    repeat (n) step();
  endtask

  task automatic send(logic [3:0] t, logic [3:0] u, logic f, bit keep);
    int n;
    tens = t;
    units = u;
    flag = f;
    in_valid = 1'b1;
    n = 0;
    do begin
      step();
      n++;
    end while (!last_xfer && n < 64);
    tests++;
    assert (last_xfer) else begin
      fails++;
      $error("FAIL send_timeout observed=no_transfer expected=transfer");
    end
    if (!keep) in_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    run(3);
    rst_n = 1'b1;
    run(16);

    send(4'd1, 4'd8, 1'b0, 1'b0);
    run(24);
    send(4'd0, 4'd7, 1'b0, 1'b0);
    run(20);
    send(4'hA, 4'd3, 1'b0, 1'b0);
    run(18);

    send(4'd5, 4'd5, 1'b1, 1'b0);
    run(20);
    send(4'd3, 4'd3, 1'b1, 1'b0);
    run(44);
    send(4'd4, 4'd2, 1'b0, 1'b0);
    run(20);

    send(4'd2, 4'd3, 1'b0, 1'b1);
    send(4'd4, 4'd5, 1'b0, 1'b0);
    run(32);

    send(4'd6, 4'd1, 1'b0, 1'b0);
    run(2);
    rst_n = 1'b0;
    run(2);
    rst_n = 1'b1;
    run(20);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=running expected=finished");
    $fatal(1);
  end

endmodule
